// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state/direction encodings and default timing for the traffic phase scheduler
package traffic_pkg;
    typedef enum logic [2:0] {
        RED  = 3'd0,
        NSG  = 3'd1,
        NSY  = 3'd2,
        EWG  = 3'd3,
        EWY  = 3'd4,
        WALK = 3'd5
    } state_e;
    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } dir_e;
    localparam int DEF_MIN_GREEN    = 4;
    localparam int DEF_MAX_GREEN    = 10;
    localparam int DEF_YELLOW_TIME  = 3;
    localparam int DEF_ALL_RED_TIME = 2;
    localparam int DEF_WALK_TIME    = 5;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: cycles-in-state counter with synchronous clear and saturation
module phase_timer #(
    parameter int W   = 4,
    parameter int SAT = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : (cnt_q >= W'(SAT)) ? cnt_q : cnt_q + 1'b1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: two-approach intersection controller with pedestrian walk phase
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN    = DEF_MIN_GREEN,
    parameter int MAX_GREEN    = DEF_MAX_GREEN,
    parameter int YELLOW_TIME  = DEF_YELLOW_TIME,
    parameter int ALL_RED_TIME = DEF_ALL_RED_TIME,
    parameter int WALK_TIME    = DEF_WALK_TIME
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic       NS_red,
    output logic       NS_yellow,
    output logic       NS_green,
    output logic       EW_red,
    output logic       EW_yellow,
    output logic       EW_green,
    output logic       walk,
    output logic [2:0] phase
);
    localparam int TW = MAX_GREEN > 1 ? $clog2(MAX_GREEN) : 1;
    state_e        state_q, state_d;
    dir_e          dir_q, dir_d;
    logic          pend_q, pend_d;
    logic [TW-1:0] timer;
    logic          min_ok, max_ok;
    phase_timer #(.W(TW), .SAT(MAX_GREEN - 1)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_d != state_q),
        .cnt_o (timer)
    );
    assign min_ok = timer >= TW'(MIN_GREEN - 1);
    assign max_ok = timer >= TW'(MAX_GREEN - 1);
    always_comb begin
        state_d = state_q;
        case (state_q)
            RED:  state_d = (timer == TW'(ALL_RED_TIME - 1)) ? (pend_q ? WALK : (dir_q == DIR_EW ? NSG : EWG)) : RED;
            NSG:  state_d = ((ew_req | pend_q) && min_ok && (!ns_req || max_ok)) ? NSY : NSG;
            NSY:  state_d = (timer == TW'(YELLOW_TIME - 1)) ? RED : NSY;
            EWG:  state_d = ((ns_req | pend_q) && min_ok && (!ew_req || max_ok)) ? EWY : EWG;
            EWY:  state_d = (timer == TW'(YELLOW_TIME - 1)) ? RED : EWY;
            WALK: state_d = (timer == TW'(WALK_TIME - 1)) ? RED : WALK;
            default: state_d = RED;
        endcase
        // entering WALK consumes the request; presses during WALK are dropped
        pend_d = (state_d == WALK && state_q != WALK) ? 1'b0 : (ped_req && state_q != WALK) ? 1'b1 : pend_q;
        dir_d  = (state_d == NSG && state_q != NSG) ? DIR_NS : (state_d == EWG && state_q != EWG) ? DIR_EW : dir_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RED;
            dir_q   <= DIR_EW;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
        end
    end
    assign NS_green  = state_q == NSG;
    assign NS_yellow = state_q == NSY;
    assign NS_red    = !(NS_green | NS_yellow);
    assign EW_green  = state_q == EWG;
    assign EW_yellow = state_q == EWY;
    assign EW_red    = !(EW_green | EW_yellow);
    assign walk      = state_q == WALK;
    assign phase     = state_q;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed scenarios with a phase-segment scoreboard and per-cycle lamp checks
module tb_traffic_phase_scheduler;
    import traffic_pkg::*;
    logic clk = 1'b0;
    logic rst, ns_req, ew_req, ped_req;
    logic NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green, walk;
    logic [2:0] phase;
    typedef struct {
        logic [2:0] ph;
        int         n;
    } seg_t;
    seg_t sb[$];
    int n_chk = 0;
    int n_fail = 0;
    traffic_phase_scheduler dut (
        .clk(clk), .rst(rst), .ns_req(ns_req), .ew_req(ew_req), .ped_req(ped_req),
        .NS_red(NS_red), .NS_yellow(NS_yellow), .NS_green(NS_green),
        .EW_red(EW_red), .EW_yellow(EW_yellow), .EW_green(EW_green),
        .walk(walk), .phase(phase)
    );
    always #5 clk = ~clk;
    // {NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green, walk}
    function automatic logic [6:0] lamp_exp(input logic [2:0] ph);
        case (ph)
            NSG:     return 7'b0011000;
            NSY:     return 7'b0101000;
            EWG:     return 7'b1000010;
            EWY:     return 7'b1000100;
            WALK:    return 7'b1001001;
            default: return 7'b1001000;
        endcase
    endfunction
    function automatic logic [6:0] lamps();
        return {NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green, walk};
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic push(input logic [2:0] ph, input int n);
        sb.push_back('{ph, n});
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    // asserts reset mid-cycle, checks the asynchronous response, releases into cycle 0
    task automatic do_reset(input logic ns, input logic ew);
        rst = 1'b1;
        ns_req = ns;
        ew_req = ew;
        ped_req = 1'b0;
        #1;
        chk("rst_phase", phase, RED);
        chk("rst_lamps", lamps(), lamp_exp(RED));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask
    // monitor: every completed phase segment is checked against the scoreboard
    initial begin
        seg_t       e;
        logic [2:0] cur = '0;
        int         cnt = 0;
        bit         v = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                v = 0;
                continue;
            end
            chk("lamp_decode", lamps(), lamp_exp(phase));
            chk("no_conflict", ((NS_green | NS_yellow) & (EW_green | EW_yellow)) |
                               (walk & (NS_green | NS_yellow | EW_green | EW_yellow)), 0);
            if (v && phase == cur) cnt++;
            else begin
                if (v) begin
                    if (sb.size() == 0) chk("seg_unexpected", cur, 7);
                    else begin
                        e = sb.pop_front();
                        chk("seg_phase", cur, e.ph);
                        chk("seg_len", cnt, e.n);
                    end
                end
                cur = phase;
                cnt = 1;
                v = 1;
            end
        end
    end
    initial begin
        rst = 1'b1;
        ns_req = 1'b0;
        ew_req = 1'b0;
        ped_req = 1'b0;
        #1;
        chk("init_phase", phase, RED);
        chk("init_lamps", lamps(), lamp_exp(RED));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        // idle: first green is NS and rests there; a pending press is lost on reset
        push(RED, 2);
        step(30);
        chk("idle_nsg_hold", phase, NSG);
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        do_reset(1'b0, 1'b0);
        push(RED, 2);
        step(20);
        chk("ped_discarded", phase, NSG);
        // EW demand only: NS green for minimum then hand over
        do_reset(1'b0, 1'b1);
        push(RED, 2); push(NSG, 4); push(NSY, 3); push(RED, 2);
        step(20);
        chk("ew_rest", phase, EWG);
        // both demanding: alternate at max green
        do_reset(1'b1, 1'b1);
        push(RED, 2); push(NSG, 10); push(NSY, 3); push(RED, 2);
        push(EWG, 10); push(EWY, 3); push(RED, 2);
        push(NSG, 10); push(NSY, 3); push(RED, 2);
        step(54);
        chk("alt_ewg", phase, EWG);
        // pedestrian served from EW green, second press during WALK ignored
        do_reset(1'b0, 1'b1);
        push(RED, 2); push(NSG, 4); push(NSY, 3); push(RED, 2);
        push(EWG, 6); push(EWY, 3); push(RED, 2); push(WALK, 5); push(RED, 2);
        step(11);
        ew_req = 1'b0;
        step(4);
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        step(8);
        chk("in_walk", phase, WALK);
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        step(20);
        chk("post_walk_nsg", phase, NSG);
        // reset in the middle of EW yellow
        do_reset(1'b0, 1'b1);
        push(RED, 2); push(NSG, 4); push(NSY, 3); push(RED, 2); push(EWG, 4);
        step(11);
        ew_req = 1'b0;
        ns_req = 1'b1;
        step(5);
        chk("mid_ewy", phase, EWY);
        do_reset(1'b0, 1'b0);
        push(RED, 2);
        step(5);
        chk("final_nsg", phase, NSG);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter MIN_GREEN, default 4, minimum green duration in cycles (>=1).
REQ-002 Parameter MAX_GREEN, default 10, maximum green duration under contention in cycles (>=MIN_GREEN).
REQ-003 Parameter YELLOW_TIME, default 3, yellow duration in cycles (>=1).
REQ-004 Parameter ALL_RED_TIME, default 2, all-red clearance duration in cycles (>=1).
REQ-005 Parameter WALK_TIME, default 5, pedestrian walk duration in cycles (>=1).
REQ-006 Port clk  input  1  single system clock, rising edge.
REQ-007 Port rst  input  1  reset, asynchronous, active-high.
REQ-008 Port ns_req  input  1  level: vehicle present on NS approach.
REQ-009 Port ew_req  input  1  level: vehicle present on EW approach.
REQ-010 Port ped_req  input  1  single-cycle pedestrian button pulse.
REQ-011 Ports NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green  output  1 each  lamp drives.
REQ-012 Port walk  output  1  pedestrian walk lamp.
REQ-013 Port phase  output  3  current state encoding, for debug.

Function
REQ-014 Moore FSM, states: RED, NSG, NSY, EWG, EWY, WALK; outputs decoded from state register only.
REQ-015 Lamps: NSG -> NS_green+EW_red; NSY -> NS_yellow+EW_red; EWG -> EW_green+NS_red; EWY -> EW_yellow+NS_red; RED and WALK -> NS_red+EW_red; walk=1 only in WALK; exactly one lamp per direction at all times.
REQ-016 Timer counts cycles spent in current state: 0 in first cycle of a state, +1 per cycle, saturating at MAX_GREEN-1; cleared on every state change.
REQ-017 ped_pending flag set by ped_req; cleared on entry to WALK; ped_req in the WALK-entry cycle or during WALK is ignored.
REQ-018 last_dir register records direction (NS/EW) of most recent green; updated on entry to NSG/EWG.
REQ-019 In NSG: demand = ew_req | ped_pending; go NSY when demand and timer>=MIN_GREEN-1 and (!ns_req or timer>=MAX_GREEN-1); otherwise stay (rest in green indefinitely without demand). EWG symmetric with ns_req/ew_req swapped.
REQ-020 NSY/EWY last exactly YELLOW_TIME cycles, then RED.
REQ-021 RED lasts exactly ALL_RED_TIME cycles, then: WALK if ped_pending; else NSG if last_dir==EW; else EWG.
REQ-022 WALK lasts exactly WALK_TIME cycles, then RED; last_dir unchanged so the direction not previously served gets the next green.
REQ-023 Green-to-green transition always passes through yellow then RED; no direct green-to-green or yellow-to-green path.
REQ-024 Illegal state encoding recovers to RED next cycle with all-red lamps.

Reset
REQ-025 rst asserted: state=RED, timer=0, ped_pending=0, last_dir=EW, immediately (no clock needed); outputs NS_red=EW_red=1, all others 0, walk=0.
REQ-026 After rst deassertion, first green is NSG after ALL_RED_TIME cycles; reset mid-phase discards pending requests.

Structure
REQ-027 Shared package traffic_pkg holds state encodings, direction encoding, and default timing constants.
REQ-028 One sub-module, phase_timer: counter with synchronous clear and saturation, async reset; FSM instantiates it once.

Verification (defaults)
REQ-029 rst released, all requests 0 -> RED 2 cycles, then NSG held indefinitely, EW_red=1 throughout.
REQ-030 In NSG, ew_req=1, ns_req=0 from entry -> NS_green exactly 4 cycles, NS_yellow 3, all-red 2, then EW_green.
REQ-031 ns_req=ew_req=1 held -> greens alternate, each exactly 10 cycles, separated by 3 yellow + 2 all-red.
REQ-032 ped_req pulse during EWG (demand present, timer>=3) -> EWY 3, RED 2, walk=1 for 5 cycles, RED 2, then NSG; second ped_req during WALK produces no further WALK.
REQ-033 rst asserted mid-EWY -> lamps become all-red and walk=0 before next clock edge; phase=RED.
REQ-034 Throughout all scenarios assertion: never green/yellow on both directions, never walk with any green/yellow.
